mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/soc_bus_pkg.sv | 16 +
 rtl/arb_pick2.sv | 18 +
 rtl/mem_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_arbiter.sv | 347 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_bus_pkg.sv
// Shared bus types and constants for the memory arbiter.
// FSM state encoding, master indices and BRAM read latency.
package soc_bus_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic M_CPU = 1'b0;
    localparam logic M_LDR = 1'b1;

    localparam int MEM_RD_LAT = 1;

endpackage

// File: rtl/arb_pick2.sv
// Two-way grant picker, purely combinational.
// On a tie the master that did not win last time is chosen.
module arb_pick2
    import soc_bus_pkg::*;
(
    input  logic [1:0] i_req,
    input  logic       i_last,
    output logic       o_grant,
    output logic       o_valid
);

    logic w_tie;

    assign w_tie   = &i_req;
    assign o_valid = |i_req;
    assign o_grant = w_tie ? ~i_last : i_req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-master BRAM arbiter: CPU (m0) and UART loader (m1).
// Define MEM_ARBITER_RR_EN for round-robin; default is m0 priority.
module mem_arbiter
    import soc_bus_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = 1536
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [3:0]        m0_wmask,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [31:0]       m0_wdata,
    output logic [31:0]       m0_rdata,
    output logic              m0_ack,
    output logic              m0_err,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [3:0]        m1_wmask,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [31:0]       m1_wdata,
    output logic [31:0]       m1_rdata,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic [3:0]        mem_wmask,
    output logic              mem_rstrb,
    input  logic [31:0]       mem_rdata
);

    localparam logic [ADDR_W:0] LP_LIMIT = (ADDR_W+1)'(MEM_WORDS * 4);

    arb_state_t        r_state;
    logic              r_win;
    logic              r_last;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic              r_we;
    logic              r_oor;
    logic              r_rstrb;
    logic [3:0]        r_wmask;
    logic              r_ack0;
    logic              r_ack1;
    logic              r_rdok;

    logic              w_grant;
    logic              w_valid;
    logic [ADDR_W-1:0] w_addr;
    logic [31:0]       w_wdata;
    logic [3:0]        w_wmask;
    logic              w_we;
    logic              w_oor;

    arb_pick2 u_pick (
        .i_req   ({m1_req, m0_req}),
        .i_last  (r_last),
        .o_grant (w_grant),
        .o_valid (w_valid)
    );

    assign w_addr  = w_grant ? m1_addr  : m0_addr;
    assign w_wdata = w_grant ? m1_wdata : m0_wdata;
    assign w_wmask = w_grant ? m1_wmask : m0_wmask;
    assign w_we    = w_grant ? m1_we    : m0_we;
    assign w_oor   = {1'b0, w_addr} >= LP_LIMIT;

    // Strobes are loaded on entry to ACCESS so they are high for that cycle only.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            r_state <= IDLE;
            r_win   <= M_CPU;
            r_last  <= M_LDR;
            r_addr  <= '0;
            r_wdata <= '0;
            r_we    <= 1'b0;
            r_oor   <= 1'b0;
            r_rstrb <= 1'b0;
            r_wmask <= '0;
            r_ack0  <= 1'b0;
            r_ack1  <= 1'b0;
            r_rdok  <= 1'b0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    r_ack0 <= 1'b0;
                    r_ack1 <= 1'b0;
                    r_rdok <= 1'b0;
                    if (w_valid) begin
                        r_win   <= w_grant;
                        r_addr  <= w_addr;
                        r_wdata <= w_wdata;
                        r_we    <= w_we;
                        r_oor   <= w_oor;
                        r_rstrb <= !w_we && !w_oor;
                        r_wmask <= (w_we && !w_oor) ? w_wmask : 4'h0;
`ifdef MEM_ARBITER_RR_EN
                        r_last  <= w_grant;
`endif
                        r_state <= ACCESS;
                    end
                end
                ACCESS: begin
                    r_rstrb <= 1'b0;
                    r_wmask <= 4'h0;
                    r_ack0  <= (r_win == M_CPU);
                    r_ack1  <= (r_win == M_LDR);
                    r_rdok  <= !r_we && !r_oor;
                    r_state <= RESP;
                end
                RESP: begin
                    r_ack0  <= 1'b0;
                    r_ack1  <= 1'b0;
                    r_rdok  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_wmask = r_wmask;
    assign mem_rstrb = r_rstrb;

    assign m0_ack   = r_ack0;
    assign m1_ack   = r_ack1;
    assign m0_err   = r_ack0 & r_oor;
    assign m1_err   = r_ack1 & r_oor;
    assign m0_rdata = (r_ack0 && r_rdok) ? mem_rdata : 32'h0;
    assign m1_rdata = (r_ack1 && r_rdok) ? mem_rdata : 32'h0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural BRAM.
// Tie-order expectations follow MEM_ARBITER_RR_EN.
module tb_mem_arbiter;

    localparam int ADDR_W    = 32;
    localparam int MEM_WORDS = 1536;

    logic              CLK = 1'b0;
    logic              RESET = 1'b0;
    logic              m0_req = 1'b0, m0_we = 1'b0;
    logic [3:0]        m0_wmask = '0;
    logic [ADDR_W-1:0] m0_addr = '0;
    logic [31:0]       m0_wdata = '0;
    logic [31:0]       m0_rdata;
    logic              m0_ack, m0_err;
    logic              m1_req = 1'b0, m1_we = 1'b0;
    logic [3:0]        m1_wmask = '0;
    logic [ADDR_W-1:0] m1_addr = '0;
    logic [31:0]       m1_wdata = '0;
    logic [31:0]       m1_rdata;
    logic              m1_ack, m1_err;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [3:0]        mem_wmask;
    logic              mem_rstrb;
    logic [31:0]       mem_rdata = '0;

    int n_vec = 0;
    int n_bad = 0;

    logic [31:0] bram [MEM_WORDS];

    always #5 CLK = ~CLK;

    mem_arbiter #(.ADDR_W(ADDR_W), .MEM_WORDS(MEM_WORDS)) dut (
        .CLK(CLK), .RESET(RESET),
        .m0_req(m0_req), .m0_we(m0_we), .m0_wmask(m0_wmask),
        .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_rdata(m0_rdata),
        .m0_ack(m0_ack), .m0_err(m0_err),
        .m1_req(m1_req), .m1_we(m1_we), .m1_wmask(m1_wmask),
        .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_rdata(m1_rdata),
        .m1_ack(m1_ack), .m1_err(m1_err),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
        .mem_rstrb(mem_rstrb), .mem_rdata(mem_rdata)
    );

    wire [29:0] w_idx = mem_addr[31:2];

    always @(posedge CLK) begin
        if (w_idx < MEM_WORDS) begin
            if (mem_rstrb) mem_rdata <= bram[w_idx];
            for (int b = 0; b < 4; b++)
                if (mem_wmask[b]) bram[w_idx][8*b +: 8] <= mem_wdata[8*b +: 8];
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic drive0(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        m0_req = req; m0_we = we; m0_addr = addr; m0_wdata = wdata; m0_wmask = wmask;
    endtask

    task automatic drive1(input logic req, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] wmask);
        m1_req = req; m1_we = we; m1_addr = addr; m1_wdata = wdata; m1_wmask = wmask;
    endtask

    task automatic test_reset();
        logic [143:0] got;
        RESET = 1'b0;
        tick(); tick();
        got = {m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               mem_rstrb, mem_wmask, mem_addr, mem_wdata};
        n_vec++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h want 0", got);
        end
        RESET = 1'b1;
        tick();
        n_vec++;
        if ({m0_ack, m1_ack, mem_rstrb} !== 3'b000) begin
            n_bad++;
            $display("FAIL idle_quiet: got %b want 000", {m0_ack, m1_ack, mem_rstrb});
        end
    endtask

    task automatic test_read();
        bram[4] = 32'hDEADBEEF;
        drive0(1, 0, 32'h10, 0, 0);
        tick();
        n_vec++;
        if ({mem_rstrb, mem_wmask, mem_addr, m0_ack} !== {1'b1, 4'h0, 32'h10, 1'b0}) begin
            n_bad++;
            $display("FAIL read_access: got rstrb=%b wm=%h addr=%h ack=%b want 1 0 10 0",
                     mem_rstrb, mem_wmask, mem_addr, m0_ack);
        end
        tick();
        n_vec++;
        if ({m0_ack, m0_err, m0_rdata, m1_ack, mem_rstrb} !== {2'b10, 32'hDEADBEEF, 2'b00}) begin
            n_bad++;
            $display("FAIL read_resp: got ack=%b err=%b rd=%h m1ack=%b rstrb=%b want 1 0 deadbeef 0 0",
                     m0_ack, m0_err, m0_rdata, m1_ack, mem_rstrb);
        end
        drive0(0, 0, 0, 0, 0);
        tick();
        n_vec++;
        if ({m0_ack, m0_rdata, mem_addr} !== {1'b0, 32'h0, 32'h10}) begin
            n_bad++;
            $display("FAIL read_after: got ack=%b rd=%h addr=%h want 0 0 10",
                     m0_ack, m0_rdata, mem_addr);
        end
    endtask

    task automatic test_write_readback();
        drive1(1, 1, 32'h20, 32'h12345678, 4'hF);
        tick();
        n_vec++;
        if ({mem_wmask, mem_rstrb, mem_wdata} !== {4'hF, 1'b0, 32'h12345678}) begin
            n_bad++;
            $display("FAIL write_access: got wm=%h rstrb=%b wd=%h want f 0 12345678",
                     mem_wmask, mem_rstrb, mem_wdata);
        end
        tick();
        n_vec++;
        if ({m1_ack, m1_err, m1_rdata, m0_ack, mem_wmask} !== {2'b10, 32'h0, 1'b0, 4'h0}) begin
            n_bad++;
            $display("FAIL write_resp: got ack=%b err=%b rd=%h m0ack=%b wm=%h want 1 0 0 0 0",
                     m1_ack, m1_err, m1_rdata, m0_ack, mem_wmask);
        end
        drive1(0, 0, 0, 0, 0);
        tick();
        drive0(1, 0, 32'h20, 0, 0);
        tick(); tick();
        n_vec++;
        if ({m0_ack, m0_rdata} !== {1'b1, 32'h12345678}) begin
            n_bad++;
            $display("FAIL write_readback: got ack=%b rd=%h want 1 12345678", m0_ack, m0_rdata);
        end
        drive0(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_partial_write();
        bram[12] = 32'hFFFFFFFF;
        drive0(1, 1, 32'h30, 32'hAAAABBBB, 4'h3);
        tick();
        n_vec++;
        if (mem_wmask !== 4'h3) begin
            n_bad++;
            $display("FAIL partial_mask: got %h want 3", mem_wmask);
        end
        tick();
        drive0(0, 0, 0, 0, 0);
        tick();
        drive0(1, 0, 32'h30, 0, 0);
        tick(); tick();
        n_vec++;
        if ({m0_ack, m0_rdata} !== {1'b1, 32'hFFFFBBBB}) begin
            n_bad++;
            $display("FAIL partial_readback: got ack=%b rd=%h want 1 ffffbbbb", m0_ack, m0_rdata);
        end
        drive0(0, 0, 0, 0, 0);
        tick();
    endtask

    task automatic test_out_of_range();
        bram[MEM_WORDS-1] = 32'hCAFEF00D;
        drive0(1, 0, MEM_WORDS*4 - 4, 0, 0);
        tick();
        n_vec++;
        if (mem_rstrb !== 1'b1) begin
            n_bad++;
            $display("FAIL last_word_strobe: got %b want 1", mem_rstrb);
        end
        tick();
        n_vec++;
        if ({m0_ack, m0_err, m0_rdata} !== {2'b10, 32'hCAFEF00D}) begin
            n_bad++;
            $display("FAIL last_word_resp: got ack=%b err=%b rd=%h want 1 0 cafef00d",
                     m0_ack, m0_err, m0_rdata);
        end
        drive0(0, 0, 0, 0, 0);
        tick();
        drive0(1, 0, MEM_WORDS*4, 0, 0);
        tick();
        n_vec++;
        if ({mem_rstrb, mem_wmask} !== 5'b0) begin
            n_bad++;
            $display("FAIL oor_read_access: got rstrb=%b wm=%h want 0 0", mem_rstrb, mem_wmask);
        end
        tick();
        n_vec++;
        if ({m0_ack, m0_err, m0_rdata} !== {2'b11, 32'h0}) begin
            n_bad++;
            $display("FAIL oor_read_resp: got ack=%b err=%b rd=%h want 1 1 0",
                     m0_ack, m0_err, m0_rdata);
        end
        drive0(0, 0, 0, 0, 0);
        tick();
        drive1(1, 1, 32'hFFFF_FFF0, 32'h55555555, 4'hF);
        tick();
        n_vec++;
        if ({mem_rstrb, mem_wmask} !== 5'b0) begin
            n_bad++;
            $display("FAIL oor_write_access: got rstrb=%b wm=%h want 0 0", mem_rstrb, mem_wmask);
        end
        tick();
        n_vec++;
        if ({m1_ack, m1_err, m1_rdata, m0_err} !== {2'b11, 32'h0, 1'b0}) begin
            n_bad++;
            $display("FAIL oor_write_resp: got ack=%b err=%b rd=%h m0err=%b want 1 1 0 0",
                     m1_ack, m1_err, m1_rdata, m0_err);
        end
        drive1(0, 0, 0, 0, 0);
        tick();
        n_vec++;
        if ({m1_ack, m1_err} !== 2'b00) begin
            n_bad++;
            $display("FAIL oor_err_clear: got ack=%b err=%b want 0 0", m1_ack, m1_err);
        end
    endtask

    task automatic test_dropped_req();
        bram[2] = 32'h0BADCAFE;
        drive0(1, 0, 32'h8, 0, 0);
        tick();
        drive0(0, 0, 0, 0, 0);
        tick();
        n_vec++;
        if ({m0_ack, m0_rdata} !== {1'b1, 32'h0BADCAFE}) begin
            n_bad++;
            $display("FAIL dropped_req: got ack=%b rd=%h want 1 0badcafe", m0_ack, m0_rdata);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_order;
        logic [3:0] got_order;
        int         n_ack;
        int         last_cyc;
`ifdef MEM_ARBITER_RR_EN
        exp_order = 4'b1010;
`else
        exp_order = 4'b0000;
`endif
        got_order = '0;
        n_ack = 0;
        last_cyc = -1;
        drive0(1, 0, 32'h10, 0, 0);
        drive1(1, 0, 32'h20, 0, 0);
        for (int c = 1; c <= 40 && n_ack < 4; c++) begin
            tick();
            if (m0_ack && m1_ack) begin
                n_vec++;
                n_bad++;
                $display("FAIL dual_ack: cycle %0d both acks high, want one", c);
            end else if (m0_ack || m1_ack) begin
                got_order[n_ack] = m1_ack;
                n_vec++;
                if (c - last_cyc !== ((last_cyc < 0) ? c + 1 : 3)) begin
                    n_bad++;
                    $display("FAIL ack_spacing: ack %0d at cycle %0d, previous %0d", n_ack, c, last_cyc);
                end
                last_cyc = c;
                n_ack++;
            end
        end
        n_vec++;
        if (n_ack !== 4) begin
            n_bad++;
            $display("FAIL tie_ack_count: got %0d want 4", n_ack);
        end
        n_vec++;
        if (got_order !== exp_order) begin
            n_bad++;
            $display("FAIL tie_order: got %b want %b (bit i = master of ack i)", got_order, exp_order);
        end
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    task automatic test_reset_abort();
        logic [143:0] got;
        drive1(1, 0, 32'h10, 0, 0);
        tick();
        n_vec++;
        if (mem_rstrb !== 1'b1) begin
            n_bad++;
            $display("FAIL abort_access: got rstrb=%b want 1", mem_rstrb);
        end
        RESET = 1'b0;
        tick();
        got = {m0_ack, m1_ack, m0_err, m1_err, m0_rdata, m1_rdata,
               mem_rstrb, mem_wmask, mem_addr, mem_wdata};
        n_vec++;
        if (got !== '0) begin
            n_bad++;
            $display("FAIL abort_outputs: got %h want 0", got);
        end
        RESET = 1'b1;
        drive0(1, 0, 32'h40, 0, 0);
        drive1(1, 0, 32'h80, 0, 0);
        tick();
        n_vec++;
        if ({m1_ack, mem_addr} !== {1'b0, 32'h40}) begin
            n_bad++;
            $display("FAIL abort_tie_grant: got m1ack=%b addr=%h want 0 40", m1_ack, mem_addr);
        end
        tick();
        n_vec++;
        if ({m0_ack, m1_ack} !== 2'b10) begin
            n_bad++;
            $display("FAIL abort_tie_ack: got m0=%b m1=%b want 1 0", m0_ack, m1_ack);
        end
        drive0(0, 0, 0, 0, 0);
        drive1(0, 0, 0, 0, 0);
        repeat (4) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < MEM_WORDS; i++) bram[i] = 32'h0;
        test_reset();
        test_read();
        test_write_readback();
        test_partial_write();
        test_out_of_range();
        test_dropped_req();
        test_back_to_back();
        test_reset_abort();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
